// File: rtl/segled_pkg.sv
// rtl/segled_pkg.sv - shared constants, state type and blanking helper for segled_bcd_master
// Optional leading-zero blanking is selected with SEGLED_BCD_BLANK_EN.
package segled_pkg;

    localparam logic [31:0] SEGLED_CFG_OFS  = 32'h0000_0000;
    localparam logic [31:0] SEGLED_DAT_OFS  = 32'h0000_0004;
    localparam logic [13:0] SEGLED_MAX_DEC  = 14'd9999;
    localparam logic [31:0] SEGLED_INIT_CFG = 32'h0101_0101;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_CONV,
`ifdef SEGLED_BCD_BLANK_EN
        ST_WR_CFG,
`endif
        ST_WR_DAT
    } segled_state_t;

    // A digit stays lit if it or any more significant digit is non-zero; ones always lit.
    function automatic logic [31:0] blank_cfg(input logic [15:0] bcd);
        logic en3, en2, en1;
        en3 = (bcd[15:12] != 4'h0);
        en2 = en3 | (bcd[11:8] != 4'h0);
        en1 = en2 | (bcd[7:4] != 4'h0);
        return {7'b0, en3, 7'b0, en2, 7'b0, en1, 7'b0, 1'b1};
    endfunction

endpackage

// File: rtl/segled_bcd_master_if.sv
// rtl/segled_bcd_master_if.sv - Wishbone32 write bus between segled_bcd_master and the segment peripheral
interface segled_bcd_master_if;

    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic        wb_ack_i;
    logic [31:0] wb_dat_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
        input  wb_ack_i, wb_dat_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
        output wb_ack_i, wb_dat_i
    );

endinterface

// File: rtl/segled_bcd_master_bin2bcd.sv
// rtl/segled_bcd_master_bin2bcd.sv - sequential 14-bit binary to 4-digit BCD double-dabble
// One shift per cycle after start; done pulses for one cycle after the 14th shift.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [13:0] bin,
    output logic        done,
    output logic [15:0] bcd
);

    logic [13:0] bin_q;
    logic [15:0] bcd_q;
    logic [3:0]  cnt_q;
    logic        run_q;
    logic        done_q;
    logic [15:0] bcd_adj;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (start) begin
            bin_q  <= bin;
            bcd_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b1;
            done_q <= 1'b0;
        end else if (run_q) begin
            bcd_q  <= {bcd_adj[14:0], bin_q[13]};
            bin_q  <= {bin_q[12:0], 1'b0};
            cnt_q  <= cnt_q + 4'd1;
            run_q  <= (cnt_q != 4'd13);
            done_q <= (cnt_q == 4'd13);
        end else begin
            done_q <= 1'b0;
        end
    end

    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/segled_bcd_master.sv
// rtl/segled_bcd_master.sv - binary value to BCD, written to the seven-segment peripheral over Wishbone
// Define SEGLED_BCD_BLANK_EN to add a leading-zero blanking config write before each data write.
module segled_bcd_master
    import segled_pkg::*;
#(
    parameter logic [31:0] SEG_BASE = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 val_valid,
    input  logic [13:0]          val_data,
    output logic                 val_ready,
    output logic                 ovf,
    output logic                 busy,
    segled_bcd_master_if.master  wb
);

    segled_state_t state_q, state_d;
    logic          cyc_q, cyc_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic          ovf_q, ovf_d;
    logic          start;
    logic          conv_done;
    logic [13:0]   sat_val;
    logic [15:0]   bcd;
    logic          unused_dat;

    assign unused_dat = ^wb.wb_dat_i;
    assign sat_val    = (val_data > SEGLED_MAX_DEC) ? SEGLED_MAX_DEC : val_data;
    assign start      = (state_q == ST_IDLE) && val_valid;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (sat_val),
        .done  (conv_done),
        .bcd   (bcd)
    );

    // Each write state first raises the strobe, then waits for ack; dropping it on
    // ack guarantees a low cycle before the next state can raise it again.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_INIT: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                    adr_d = SEG_BASE + SEGLED_CFG_OFS;
                    dat_d = SEGLED_INIT_CFG;
                end else if (wb.wb_ack_i) begin
                    cyc_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (val_valid) begin
                    ovf_d   = (val_data > SEGLED_MAX_DEC);
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                if (conv_done) begin
`ifdef SEGLED_BCD_BLANK_EN
                    state_d = ST_WR_CFG;
`else
                    state_d = ST_WR_DAT;
`endif
                end
            end
`ifdef SEGLED_BCD_BLANK_EN
            ST_WR_CFG: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                    adr_d = SEG_BASE + SEGLED_CFG_OFS;
                    dat_d = blank_cfg(bcd);
                end else if (wb.wb_ack_i) begin
                    cyc_d   = 1'b0;
                    state_d = ST_WR_DAT;
                end
            end
`endif
            ST_WR_DAT: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                    adr_d = SEG_BASE + SEGLED_DAT_OFS;
                    dat_d = {4'h0, bcd[15:12], 4'h0, bcd[11:8], 4'h0, bcd[7:4], 4'h0, bcd[3:0]};
                end else if (wb.wb_ack_i) begin
                    cyc_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cyc_d   = 1'b0;
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_INIT;
            cyc_q   <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            ovf_q   <= ovf_d;
        end
    end

    assign val_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign ovf         = ovf_q;
    assign wb.wb_cyc_o = cyc_q;
    assign wb.wb_stb_o = cyc_q;
    assign wb.wb_we_o  = cyc_q;
    assign wb.wb_sel_o = {4{cyc_q}};
    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = dat_q;

endmodule

// File: tb/tb_segled_bcd_master.sv
// tb/tb_segled_bcd_master.sv - randomized self-checking bench for segled_bcd_master
module tb_segled_bcd_master;

    localparam logic [31:0] BASE = 32'h0000_0100;
`ifdef SEGLED_BCD_BLANK_EN
    localparam int NTX = 2;
`else
    localparam int NTX = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        val_valid = 1'b0;
    logic [13:0] val_data = '0;
    logic        val_ready, ovf, busy;

    int n_chk = 0;
    int n_err = 0;
    int ack_delay = 0;
    int wait_cnt = 0;
    int viol = 0;

    logic [63:0] wlog[$];
    logic        hold = 1'b0;
    logic        prev_ack = 1'b0;
    logic [31:0] cap_adr = '0;
    logic [31:0] cap_dat = '0;

    segled_bcd_master_if wb();

    segled_bcd_master #(.SEG_BASE(BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .val_valid (val_valid),
        .val_data  (val_data),
        .val_ready (val_ready),
        .ovf       (ovf),
        .busy      (busy),
        .wb        (wb.master)
    );

    always #5 clk = ~clk;

    assign wb.wb_dat_i = 32'hDEAD_BEEF;

    // Registered slave: acks ack_delay cycles after first seeing the strobe.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb.wb_ack_i <= 1'b0;
            wait_cnt    <= 0;
        end else if (!(wb.wb_cyc_o && wb.wb_stb_o) || wb.wb_ack_i) begin
            wb.wb_ack_i <= 1'b0;
            wait_cnt    <= 0;
        end else if (wait_cnt >= ack_delay) begin
            wb.wb_ack_i <= 1'b1;
        end else begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    always @(posedge clk) begin
        if (wb.wb_cyc_o && wb.wb_stb_o && wb.wb_ack_i)
            wlog.push_back({wb.wb_adr_o, wb.wb_dat_o});
        if (wb.wb_cyc_o !== wb.wb_stb_o) viol++;
        if (wb.wb_cyc_o && (wb.wb_we_o !== 1'b1 || wb.wb_sel_o !== 4'hF)) viol++;
        if (hold && wb.wb_cyc_o && (wb.wb_adr_o !== cap_adr || wb.wb_dat_o !== cap_dat)) viol++;
        if (hold && !wb.wb_cyc_o && rst) viol++;
        if (prev_ack && wb.wb_cyc_o) viol++;
        hold     <= wb.wb_cyc_o && !wb.wb_ack_i;
        prev_ack <= wb.wb_cyc_o && wb.wb_ack_i;
        cap_adr  <= wb.wb_adr_o;
        cap_dat  <= wb.wb_dat_o;
    end

    function automatic logic [31:0] exp_dat(int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return {4'h0, 4'(s / 1000), 4'h0, 4'((s / 100) % 10),
                4'h0, 4'((s / 10) % 10), 4'h0, 4'(s % 10)};
    endfunction

    function automatic logic [31:0] exp_cfg(int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return {7'b0, 1'(s >= 1000), 7'b0, 1'(s >= 100), 7'b0, 1'(s >= 10), 8'h01};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input int bound, input bit noise, output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
            if (noise && !val_ready) begin
                val_valid = 1'($urandom_range(0, 1));
                val_data  = 14'($urandom);
            end else begin
                val_valid = 1'b0;
            end
        end while (!val_ready && cycles < bound);
        val_valid = 1'b0;
        if (!val_ready) check("ready_timeout", val_ready, 1'b1);
    endtask

    task automatic run_value(input int v, input bit noise, input string tag);
        int lat;
        wlog.delete();
        val_data  = 14'(v);
        val_valid = 1'b1;
        @(posedge clk);
        #1;
        val_valid = 1'b0;
        check({tag, "_ovf"}, ovf, (v > 9999) ? 1 : 0);
        check({tag, "_busy"}, busy, 1'b1);
        wait_ready(1000, noise, lat);
        check({tag, "_lat"}, lat, 15 + NTX * (3 + ack_delay));
        check({tag, "_nwr"}, wlog.size(), NTX);
        if (wlog.size() == NTX) begin
            if (NTX == 2) check({tag, "_cfg"}, wlog[0], {BASE, exp_cfg(v)});
            check({tag, "_dat"}, wlog[NTX-1], {BASE + 32'h4, exp_dat(v)});
        end
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_quiet"}, wlog.size(), NTX);
    endtask

    initial begin
        int lat;
        int found;
        int dir[11] = '{1234, 42, 12000, 0, 9999, 10000, 16383, 9, 10, 100, 1000};

        repeat (3) @(posedge clk);
        #1;
        check("rst_cyc", wb.wb_cyc_o, 1'b0);
        check("rst_stb", wb.wb_stb_o, 1'b0);
        check("rst_we_sel", {wb.wb_we_o, wb.wb_sel_o}, 5'b0);
        check("rst_adr_dat", {wb.wb_adr_o, wb.wb_dat_o}, 64'h0);
        check("rst_ready", val_ready, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_busy", busy, 1'b1);

        wlog.delete();
        @(negedge clk);
        rst = 1'b1;
        wait_ready(100, 1'b0, lat);
        check("init_lat", lat, 3);
        check("init_nwr", wlog.size(), 1);
        if (wlog.size() == 1) check("init_wr", wlog[0], {BASE, 32'h0101_0101});

        foreach (dir[i]) run_value(dir[i], 1'b0, $sformatf("dir%0d", dir[i]));

        for (int i = 0; i < 20; i++) begin
            int v;
            ack_delay = $urandom_range(0, 3);
            v = (i % 4 == 0) ? $urandom_range(9990, 10010) : $urandom_range(0, 16383);
            run_value(v, 1'b0, $sformatf("rnd%0d_%0d", i, v));
        end

        ack_delay = 10;
        run_value(5678, 1'b1, "stall");

        ack_delay = 5;
        wlog.delete();
        val_data  = 14'd1234;
        val_valid = 1'b1;
        @(posedge clk);
        #1;
        val_valid = 1'b0;
        found = 0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            @(posedge clk);
            #1;
            if (wb.wb_cyc_o && wb.wb_adr_o == BASE + 32'h4) found = 1;
        end
        check("abort_reach_dat", found, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_cyc", wb.wb_cyc_o, 1'b0);
        check("abort_stb", wb.wb_stb_o, 1'b0);
        check("abort_busy", {busy, val_ready}, 2'b10);
        repeat (3) @(posedge clk);
        ack_delay = 0;
        wlog.delete();
        @(negedge clk);
        rst = 1'b1;
        wait_ready(100, 1'b0, lat);
        check("reinit_lat", lat, 3);
        check("reinit_nwr", wlog.size(), 1);
        if (wlog.size() == 1) check("reinit_wr", wlog[0], {BASE, 32'h0101_0101});

        run_value(42, 1'b0, "post_abort");

        check("wb_protocol", viol, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
